wb_initiator: RTL and testbench

Wishbone classic bus master that turns a simple valid/ready request stream (address, data, write-enable, byte-select) into single Wishbone read/write cycles, and returns a response on a valid/ready channel. It is the initiator counterpart to the multiplexer's Wishbone slave port. It drives on-chip peripherals and serves as a bus-functional master when verifying the slave side. A request FIFO decouples producers, and a per-cycle timeout guarantees forward progress when a slave never acknowledges.

---
 rtl/wb_initiator.sv | 141 ++++++++++++++
 tb/tb_wb_initiator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// ============================================================================
// Module      : wb_initiator
// Description : Wishbone classic master fed by a queued valid/ready request
//               stream, returning one response per bus cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_initiator #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam int EW = 69;
    localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [EW-1:0]   r_mem [FIFO_DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic [EW-1:0]   w_head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign req_ready = !w_full;
    assign w_push  = req_valid && !w_full;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {req_we, req_sel, req_dat, req_adr};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd_ptr  <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        {wbm_we_o, wbm_sel_o, wbm_dat_o, wbm_adr_o} <= w_head;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_BUS;
                    end
                end
                S_BUS: begin
                    // Ack takes priority over an expiring timeout in the same cycle.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_rd_ptr  <= r_rd_ptr + (AW+1)'(1);
                        r_state   <= S_RESP;
                    end else if (r_cnt == C_TMO_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= 32'd0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        r_rd_ptr  <= r_rd_ptr + (AW+1)'(1);
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_initiator.sv
// ============================================================================
// Module      : tb_wb_initiator
// Description : Directed self-checking bench for wb_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we_o, ack;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o, dat_i;

    int checks = 0;
    int errors = 0;

    wb_initiator #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_adr  (req_adr),
        .req_dat  (req_dat),
        .req_sel  (req_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o (we_o),
        .wbm_sel_o(sel_o),
        .wbm_adr_o(adr_o),
        .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i),
        .wbm_ack_i(ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w);
        req_valid = 1'b1;
        req_adr   = a;
        req_dat   = d;
        req_sel   = s;
        req_we    = w;
        step();
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for strobe, checks the address, acks after 'dly' strobe cycles.
    task automatic service(input int dly, input logic [31:0] rd, input logic [31:0] exp_adr);
        int n;
        n = 0;
        while (!stb && n < 20) begin
            step();
            n++;
        end
        chk("stb_wait", stb, 1);
        chk("adr_o", adr_o, exp_adr);
        for (int i = 0; i < dly; i++) step();
        ack   = 1'b1;
        dat_i = rd;
        step();
        ack   = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
        req_sel = '0; rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
        step();
        step();
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        step();

        // Read, acked in the second strobe cycle
        push(32'h3000_0004, 32'h0, 4'hF, 1'b0);
        chk("rd_stb_T1", stb, 0);
        step();
        chk("rd_stb_T2", stb, 1);
        chk("rd_adr", adr_o, 32'h3000_0004);
        chk("rd_we", we_o, 0);
        chk("rd_sel", sel_o, 4'hF);
        step();
        chk("rd_cyc_2nd", cyc, 1);
        ack = 1'b1; dat_i = 32'hDEAD_BEEF;
        step();
        ack = 1'b0;
        chk("rd_cyc_drop", cyc, 0);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
        chk("rd_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rd_rsp_done", rsp_valid, 0);

        // Write, acked in the first strobe cycle
        push(32'h3000_0000, 32'h1234_5678, 4'h3, 1'b1);
        step();
        chk("wr_stb", stb, 1);
        chk("wr_dat_o", dat_o, 32'h1234_5678);
        chk("wr_sel", sel_o, 4'h3);
        chk("wr_we", we_o, 1);
        ack = 1'b1; dat_i = 32'hFFFF_FFFF;
        step();
        ack = 1'b0;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_dat", rsp_dat, 0);
        chk("wr_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Timeout: no ack ever
        push(32'h3000_0008, 32'h0, 4'hF, 1'b0);
        n = 0;
        while (!stb && n < 20) begin step(); n++; end
        chk("tmo_stb_wait", stb, 1);
        n = 0;
        while (stb && n < 40) begin step(); n++; end
        chk("tmo_stb_cycles", n, 16);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_dat", rsp_dat, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        push(32'h3000_000C, 32'h0, 4'hF, 1'b0);
        service(0, 32'hCAFE_F00D, 32'h3000_000C);
        chk("post_tmo_err", rsp_err, 0);
        chk("post_tmo_dat", rsp_dat, 32'hCAFE_F00D);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // FIFO full and response backpressure
        req_valid = 1'b1; req_we = 1'b0; req_sel = 4'hF; req_dat = '0;
        for (int i = 0; i < 4; i++) begin
            req_adr = 32'h4000_0000 + 32'(i * 4);
            chk("ff_ready_open", req_ready, 1);
            step();
        end
        req_adr = 32'h4000_0010;
        chk("ff_ready_full", req_ready, 0);
        service(0, 32'hA000_0000, 32'h4000_0000);
        chk("ff_ready_freed", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("ff_refull", req_ready, 0);
        step();
        step();
        chk("ff_rsp_held_v", rsp_valid, 1);
        chk("ff_rsp_held_d", rsp_dat, 32'hA000_0000);
        chk("ff_no_cyc", cyc, 0);
        rsp_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            service(0, 32'hA000_0000 + 32'(k), 32'h4000_0000 + 32'(k * 4));
            chk("ff_rsp_valid", rsp_valid, 1);
            chk("ff_rsp_dat", rsp_dat, 32'hA000_0000 + 32'(k));
        end
        step();
        chk("ff_drained", rsp_valid, 0);

        // Ack on the last permitted strobe cycle wins over timeout
        push(32'h3000_0010, 32'h0, 4'hF, 1'b0);
        service(15, 32'h5555_AAAA, 32'h3000_0010);
        chk("late_ack_valid", rsp_valid, 1);
        chk("late_ack_err", rsp_err, 0);
        chk("late_ack_dat", rsp_dat, 32'h5555_AAAA);
        step();

        // Reset in the middle of a bus cycle with requests queued
        push(32'h5000_0000, 32'h0, 4'hF, 1'b0);
        push(32'h5000_0004, 32'h0, 4'hF, 1'b0);
        push(32'h5000_0008, 32'h0, 4'hF, 1'b0);
        chk("mid_stb", stb, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_cyc", cyc, 0);
        chk("mid_stb_low", stb, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_req_ready", req_ready, 1);
        ack = 1'b1; dat_i = 32'h1111_2222;
        step();
        ack = 1'b0;
        step();
        step();
        chk("mid_late_ack_v", rsp_valid, 0);
        chk("mid_idle_cyc", cyc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
